// File: rtl/serial_frame_tx.sv
// serial_frame_tx: start/LSB-first data/even-parity/stop serial frame transmitter
module serial_frame_tx #(
  parameter int DATA_W = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              load,
  output logic              ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic par, par_n, tx_r, tx_n, done_r, done_n;
  logic bit_end;
  assign bit_end = cnt == 8'(CLKS_PER_BIT - 1);
  assign ready = state == IDLE;
  assign busy = ~ready;
  assign tx = tx_r;
  assign done = done_r;
  // state, counters, shift register and registered line outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      par <= 1'b0;
      tx_r <= 1'b1;
      done_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shreg <= shreg_n;
      par <= par_n;
      tx_r <= tx_n;
      done_r <= done_n;
    end
  end
  // next state: the line value for the next bit is chosen at each bit boundary
  always_comb begin
    state_n = state;
    cnt_n = state == IDLE ? '0 : (bit_end ? '0 : cnt + 8'd1);
    idx_n = idx;
    shreg_n = shreg;
    par_n = par;
    tx_n = tx_r;
    done_n = 1'b0;
    case (state)
      IDLE: if (load) begin
        state_n = START;
        shreg_n = data_in;
        par_n = ^data_in;
        idx_n = '0;
        tx_n = 1'b0;
      end
      START: if (bit_end) begin
        state_n = DATA;
        tx_n = shreg[0];
        shreg_n = shreg >> 1;
      end
      DATA: if (bit_end) begin
        if (idx == 4'(DATA_W - 1)) begin
          state_n = PARITY;
          tx_n = par;
        end else begin
          idx_n = idx + 4'd1;
          tx_n = shreg[0];
          shreg_n = shreg >> 1;
        end
      end
      PARITY: if (bit_end) begin
        state_n = STOP;
        tx_n = 1'b1;
      end
      STOP: if (bit_end) begin
        state_n = IDLE;
        tx_n = 1'b1;
        done_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: frame-level reference model feeding per-cycle scoreboards for two configurations
module tb_serial_frame_tx;
  typedef struct {logic tx, ready, done;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load = 1'b0;
  logic [15:0] din = '0;
  logic [1:0] tx_w, ready_w, busy_w, done_w;
  int vectors = 0;
  int errors = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int inst, input logic act, input logic req);
    vectors++;
    if (act !== req) begin
      errors++;
      if (errors <= 40) $display("FAIL %s inst%0d t=%0t got %b want %b", nm, inst, $time, act, req);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int DW = g == 0 ? 8 : 1;
    localparam int CPB = g == 0 ? 4 : 1;
    serial_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
      .clock(clk), .reset(rst), .data_in(din[DW-1:0]), .load(load),
      .ready(ready_w[g]), .tx(tx_w[g]), .busy(busy_w[g]), .done(done_w[g])
    );
    logic bq[$];
    exp_t eq[$];
    exp_t e;
    logic e_tx = 1'b1, e_ready = 1'b1, e_done = 1'b0;
    // reference: on acceptance expand the whole frame into a per-cycle line waveform
    always @(posedge clk) begin
      if (!rst) begin
        bq.delete();
        e_tx = 1'b1; e_ready = 1'b1; e_done = 1'b0;
      end else if (e_ready && load) begin
        bq.delete();
        repeat (CPB) bq.push_back(1'b0);
        for (int i = 0; i < DW; i++) repeat (CPB) bq.push_back(din[i]);
        repeat (CPB) bq.push_back(^din[DW-1:0]);
        repeat (CPB) bq.push_back(1'b1);
        e_tx = bq.pop_front(); e_ready = 1'b0; e_done = 1'b0;
      end else if (bq.size() > 0) begin
        e_tx = bq.pop_front(); e_ready = 1'b0; e_done = 1'b0;
      end else begin
        e_done = !e_ready; e_ready = 1'b1; e_tx = 1'b1;
      end
      eq.push_back('{e_tx, e_ready, e_done});
    end
    // monitor: compare DUT outputs mid-cycle against the oldest expected record
    always @(negedge clk) begin
      if (eq.size() > 0) begin
        e = eq.pop_front();
        chk("tx", g, tx_w[g], e.tx);
        chk("ready", g, ready_w[g], e.ready);
        chk("done", g, done_w[g], e.done);
        chk("busy", g, busy_w[g], ~e.ready);
      end
    end
  end

  task automatic wait_done();
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_w[0]) return;
    end
    errors++; vectors++;
    $display("FAIL done_timeout inst0 t=%0t got no done want done within 300 cycles", $time);
  endtask

  task automatic pulse(input logic [15:0] d);
    @(negedge clk); load = 1'b1; din = d;
    @(negedge clk); load = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    load = 1'b1; din = 16'h00F0;
    @(negedge clk); load = 1'b0; rst = 1'b1;
    load = 1'b1; din = 16'h00A5;
    @(negedge clk); load = 1'b0;
    repeat (12) @(negedge clk);
    load = 1'b1; din = 16'h003C;
    @(negedge clk); load = 1'b0; din = 16'h0000;
    wait_done();
    load = 1'b1; din = 16'h0055;
    @(negedge clk); load = 1'b0;
    wait_done();
    pulse(16'h0007);
    wait_done();
    pulse(16'h0000);
    wait_done();
    pulse(16'h00FF);
    repeat (17) @(negedge clk);
    rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    pulse(16'h0081);
    wait_done();
    repeat (3) @(negedge clk);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      load = $urandom_range(0, 3) == 0;
      din = 16'($urandom);
      rst = $urandom_range(0, 199) != 0;
    end
    @(negedge clk); load = 1'b0; rst = 1'b1;
    repeat (60) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
